temp_room_model: RTL and testbench



---
 rtl/temp_room_model.sv | 93 +++++++++
 tb/tb_temp_room_model.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/temp_room_model.sv
// temp_room_model: behavioural room plant for closed-loop controller benches.
// Integrates heater/cooler commands into a 7-bit room temperature once per
// STEP_CYCLES clocks and pulses start whenever troom is rewritten.
module temp_room_model #(
  parameter int unsigned STEP_CYCLES = 16,
  parameter int unsigned HEAT_STEP   = 2,
  parameter int unsigned COOL_STEP   = 2,
  parameter int unsigned T_INIT      = 20,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       h,
  input  logic       c,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic [6:0] tamb,
  output logic [6:0] troom,
  output logic       start,
  output logic       fault
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [7:0]       HSTEP    = 8'(HEAT_STEP);
  localparam logic [6:0]       CSTEP    = 7'(COOL_STEP);
  localparam logic [6:0]       TINIT    = 7'(T_INIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       troom_q, troom_d;
  logic             start_q, start_d;
  logic             fault_q, fault_d;
  logic [6:0]       tnext;
  logic [7:0]       heat_sum;

  // Temperature the room moves to at an update edge, from the h/c command.
  always_comb begin
    tnext    = troom_q;
    heat_sum = {1'b0, troom_q} + HSTEP;   // 8-bit so saturation sees the carry
    unique case ({h, c})
      2'b10: tnext = (heat_sum > 8'd127) ? 7'd127 : heat_sum[6:0];
      2'b01: tnext = (troom_q >= CSTEP) ? (troom_q - CSTEP) : 7'd0;
      2'b00: begin
        if (troom_q > tamb)      tnext = troom_q - 7'd1;
        else if (troom_q < tamb) tnext = troom_q + 7'd1;
        else                     tnext = troom_q;
      end
      default: tnext = troom_q;           // conflicting commands: hold
    endcase
  end

  // Next-state: load beats enable, enable beats the period counter.
  always_comb begin
    cnt_d   = cnt_q;
    troom_d = troom_q;
    start_d = 1'b0;
    fault_d = fault_q;
    if (load) begin
      troom_d = load_val;
      cnt_d   = '0;
      start_d = 1'b1;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        start_d = 1'b1;
        troom_d = tnext;
        if (h && c) fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      troom_q <= TINIT;
      start_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      troom_q <= troom_d;
      start_q <= start_d;
      fault_q <= fault_d;
    end
  end

  assign troom = troom_q;
  assign start = start_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_temp_room_model.sv
// Bench for temp_room_model: directed scenarios plus random traffic, all
// checked cycle-by-cycle against a behavioural model of the room.
module tb_temp_room_model;

  localparam int STEP = 16, HS = 2, CS = 2, TI = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, h = 1'b0, c = 1'b0, load = 1'b0;
  logic [6:0] load_val = '0, tamb = 7'd20;
  logic [6:0] troom;
  logic       start, fault;

  int n_tests = 0, n_fail = 0;

  // behavioural room state
  int m_troom, m_cnt, m_start, m_fault;

  temp_room_model #(.STEP_CYCLES(STEP), .HEAT_STEP(HS), .COOL_STEP(CS),
                    .T_INIT(TI), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .h(h), .c(c), .load(load),
    .load_val(load_val), .tamb(tamb), .troom(troom), .start(start),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_troom = TI; m_cnt = 0; m_start = 0; m_fault = 0;
  endtask

  // One clock of the room, straight from the behavioural rules.
  task automatic m_clock();
    int t;
    if (load) begin
      m_troom = int'(load_val); m_cnt = 0; m_start = 1;
    end else if (!en) begin
      m_start = 0;
    end else if (m_cnt != STEP - 1) begin
      m_cnt++; m_start = 0;
    end else begin
      m_cnt = 0; m_start = 1; t = m_troom;
      if (h && !c)      t = (t + HS > 127) ? 127 : t + HS;
      else if (!h && c) t = (t - CS < 0) ? 0 : t - CS;
      else if (!h && !c) begin
        if (t > int'(tamb)) t--;
        else if (t < int'(tamb)) t++;
      end else m_fault = 1;
      m_troom = t;
    end
  endtask

  task automatic cmp_all();
    chk("troom", int'(troom), m_troom);
    chk("start", int'(start), m_start);
    chk("fault", int'(fault), m_fault);
  endtask

  // Advance one cycle: inputs are stable since the previous falling edge.
  task automatic step();
    @(posedge clk);
    m_clock();
    @(negedge clk);
    cmp_all();
  endtask

  // Count cycles until start is seen; a blown budget is a failure.
  task automatic wait_start(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step(); n++;
      if (start) return;
    end
    chk("start_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1; m_reset(); cmp_all();
    @(negedge clk); cmp_all();
    reset = 1'b1;
  endtask

  int n;
  int exp_q[$];

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_troom", int'(troom), 20);
    chk("rst_fault", int'(fault), 0);

    // Idle at ambient: temperature holds, start every STEP cycles.
    en = 1; tamb = 7'd20;
    wait_start(n); chk("first_start", n, 16); chk("idle_troom", int'(troom), 20);
    wait_start(n); chk("period", n, 16);     chk("idle_troom2", int'(troom), 20);

    // Heating saturates at 127.
    load = 1; load_val = 7'd120; step(); load = 0;
    chk("load_start", int'(start), 1); chk("load_troom", int'(troom), 120);
    h = 1;
    exp_q = '{122, 124, 126, 127, 127};
    foreach (exp_q[i]) begin wait_start(n); chk("heat_sat", int'(troom), exp_q[i]); end
    h = 0;

    // Cooling floors at 0.
    load = 1; load_val = 7'd3; step(); load = 0; c = 1;
    exp_q = '{1, 0, 0};
    foreach (exp_q[i]) begin wait_start(n); chk("cool_floor", int'(troom), exp_q[i]); end
    c = 0;

    // Drift toward ambient in both directions.
    load = 1; load_val = 7'd30; tamb = 7'd27; step(); load = 0;
    exp_q = '{29, 28, 27, 27};
    foreach (exp_q[i]) begin wait_start(n); chk("drift_dn", int'(troom), exp_q[i]); end
    tamb = 7'd29;
    exp_q = '{28, 29, 29};
    foreach (exp_q[i]) begin wait_start(n); chk("drift_up", int'(troom), exp_q[i]); end

    // Conflicting commands: hold and latch fault until reset.
    load = 1; load_val = 7'd50; step(); load = 0; h = 1; c = 1;
    wait_start(n); chk("conf_troom", int'(troom), 50); chk("conf_fault", int'(fault), 1);
    h = 0; c = 0; tamb = 7'd50;
    wait_start(n); chk("fault_sticky", int'(fault), 1);
    do_reset(); chk("fault_clr", int'(fault), 0);

    // Mid-period reset restarts the counter; en=0 stretches the interval.
    tamb = 7'd20;
    for (int i = 0; i < 7; i++) step();
    do_reset();
    wait_start(n); chk("restart_period", n, 16);
    for (int i = 0; i < 5; i++) step();
    en = 0; for (int i = 0; i < 5; i++) step(); en = 1;
    wait_start(n); chk("stretch", n + 10, 21);

    // Load on the update edge wins over the period update.
    for (int i = 0; i < 15; i++) step();
    load = 1; load_val = 7'd99; h = 1; step(); load = 0; h = 0;
    chk("load_wins", int'(troom), 99); chk("load_wins_st", int'(start), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      h        = $urandom_range(0, 1);
      c        = $urandom_range(0, 1);
      load     = ($urandom_range(0, 60) == 0);
      load_val = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 40) == 0) tamb = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 700) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
